// File: rtl/tcp_hdr_req_arb_pkg.sv
// Shared widths and header-request layout for the TCP slow-path header arbiter.
package tcp_hdr_req_arb_pkg;

    localparam int unsigned PORT_NUM_W    = 16;
    localparam int unsigned SEQ_NUM_W     = 32;
    localparam int unsigned ACK_NUM_W     = 32;
    localparam int unsigned FLAGS_W       = 8;
    localparam int unsigned PAYLOAD_PTR_W = 15;
    localparam int unsigned WINDOW_W      = PAYLOAD_PTR_W + 1;

    // One layout for both the flattened requester slices and the output register
    typedef struct packed {
        logic [PORT_NUM_W-1:0] host_port;
        logic [PORT_NUM_W-1:0] dest_port;
        logic [SEQ_NUM_W-1:0]  seq_num;
        logic [ACK_NUM_W-1:0]  ack_num;
        logic [FLAGS_W-1:0]    flags;
        logic [WINDOW_W-1:0]   window;
    } tcp_hdr_req_t;

    localparam int unsigned HDR_REQ_W = $bits(tcp_hdr_req_t);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/tcp_hdr_req_arb_if.sv
// Producer-side and assembler-side header request signals of the arbiter.
interface tcp_hdr_req_arb_if #(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned REQ_ID_W = $clog2(NUM_REQ)
);
    import tcp_hdr_req_arb_pkg::*;

    logic [NUM_REQ-1:0]            src_hdr_req_val;
    logic [NUM_REQ-1:0]            src_hdr_req_rdy;
    logic [NUM_REQ*PORT_NUM_W-1:0] src_host_port;
    logic [NUM_REQ*PORT_NUM_W-1:0] src_dest_port;
    logic [NUM_REQ*SEQ_NUM_W-1:0]  src_seq_num;
    logic [NUM_REQ*ACK_NUM_W-1:0]  src_ack_num;
    logic [NUM_REQ*FLAGS_W-1:0]    src_flags;
    logic [NUM_REQ*WINDOW_W-1:0]   src_window;

    logic                  arb_hdr_req_val;
    logic                  arb_hdr_req_rdy;
    logic [PORT_NUM_W-1:0] arb_host_port;
    logic [PORT_NUM_W-1:0] arb_dest_port;
    logic [SEQ_NUM_W-1:0]  arb_seq_num;
    logic [ACK_NUM_W-1:0]  arb_ack_num;
    logic [FLAGS_W-1:0]    arb_flags;
    logic [WINDOW_W-1:0]   arb_window;
    logic [REQ_ID_W-1:0]   arb_req_id;

    // Environment view: producers plus the downstream assembler
    modport master (
        output src_hdr_req_val, src_host_port, src_dest_port, src_seq_num,
               src_ack_num, src_flags, src_window, arb_hdr_req_rdy,
        input  src_hdr_req_rdy, arb_hdr_req_val, arb_host_port, arb_dest_port,
               arb_seq_num, arb_ack_num, arb_flags, arb_window, arb_req_id
    );

    // Arbiter view
    modport slave (
        input  src_hdr_req_val, src_host_port, src_dest_port, src_seq_num,
               src_ack_num, src_flags, src_window, arb_hdr_req_rdy,
        output src_hdr_req_rdy, arb_hdr_req_val, arb_host_port, arb_dest_port,
               arb_seq_num, arb_ack_num, arb_flags, arb_window, arb_req_id
    );

endinterface

// File: rtl/tcp_hdr_req_arb_rr.sv
// Round-robin first-valid finder: searches ptr, ptr+1, ... mod N for a set val bit.
module rr_arbiter_ptr #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     val,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] winner_c,
    output logic             any_c
);

    int unsigned      idx;
    logic [IDX_W-1:0] idx_w;

    always_comb begin
        grant_c  = '0;
        winner_c = '0;
        any_c    = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx   = (32'(ptr) + k) % N;
            idx_w = IDX_W'(idx);
            if (!any_c && val[idx_w]) begin
                any_c          = 1'b1;
                winner_c       = idx_w;
                grant_c[idx_w] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcp_hdr_req_arb.sv
// Round-robin arbiter feeding one registered header request to the TCP header assembler.
module tcp_hdr_req_arb
    import tcp_hdr_req_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 3,
    parameter int unsigned REQ_ID_W = $clog2(NUM_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    tcp_hdr_req_arb_if.slave  bus
);

    tcp_hdr_req_t        src_hdr [NUM_REQ];
    tcp_hdr_req_t        hdr_q;
    out_state_e          state_q;
    logic [REQ_ID_W-1:0] id_q;
    logic [REQ_ID_W-1:0] rr_ptr_q;

    logic                load_en_c;
    logic [NUM_REQ-1:0]  grant_c;
    logic [REQ_ID_W-1:0] winner_c;
    logic                any_c;

    // Unflatten requester slices into the shared header layout
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign src_hdr[gi] = '{
            host_port: bus.src_host_port[gi*PORT_NUM_W +: PORT_NUM_W],
            dest_port: bus.src_dest_port[gi*PORT_NUM_W +: PORT_NUM_W],
            seq_num:   bus.src_seq_num[gi*SEQ_NUM_W +: SEQ_NUM_W],
            ack_num:   bus.src_ack_num[gi*ACK_NUM_W +: ACK_NUM_W],
            flags:     bus.src_flags[gi*FLAGS_W +: FLAGS_W],
            window:    bus.src_window[gi*WINDOW_W +: WINDOW_W]
        };
    end

    rr_arbiter_ptr #(
        .N     (NUM_REQ),
        .IDX_W (REQ_ID_W)
    ) u_rr (
        .val      (bus.src_hdr_req_val),
        .ptr      (rr_ptr_q),
        .grant_c  (grant_c),
        .winner_c (winner_c),
        .any_c    (any_c)
    );

    assign load_en_c = (state_q == OUT_EMPTY) || bus.arb_hdr_req_rdy;

    // rst_n gate keeps every producer unaccepted while reset is held
    assign bus.src_hdr_req_rdy = grant_c & {NUM_REQ{load_en_c & rst_n}};

    // Output stage: EMPTY/FULL holding register with pointer advance past each winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OUT_EMPTY;
            hdr_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else if (load_en_c) begin
            if (any_c) begin
                state_q  <= OUT_FULL;
                hdr_q    <= src_hdr[winner_c];
                id_q     <= winner_c;
                rr_ptr_q <= (winner_c == REQ_ID_W'(NUM_REQ - 1)) ? '0
                                                                  : winner_c + REQ_ID_W'(1);
            end else begin
                state_q <= OUT_EMPTY;
            end
        end
    end

    assign bus.arb_hdr_req_val = (state_q == OUT_FULL);
    assign bus.arb_host_port   = hdr_q.host_port;
    assign bus.arb_dest_port   = hdr_q.dest_port;
    assign bus.arb_seq_num     = hdr_q.seq_num;
    assign bus.arb_ack_num     = hdr_q.ack_num;
    assign bus.arb_flags       = hdr_q.flags;
    assign bus.arb_window      = hdr_q.window;
    assign bus.arb_req_id      = id_q;

endmodule

// File: tb/tb_tcp_hdr_req_arb.sv
// Randomized plus directed bench for tcp_hdr_req_arb against a queue-level reference model.
module tb_tcp_hdr_req_arb;
    import tcp_hdr_req_arb_pkg::*;

    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst_n;

    tcp_hdr_req_arb_if #(.NUM_REQ(N)) bus ();

    tcp_hdr_req_arb #(.NUM_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Producer-side stimulus state
    bit           req_val [N];
    tcp_hdr_req_t req_hdr [N];
    bit           arb_rdy;

    // Reference model: one output slot plus a next-to-search pointer
    bit           m_val;
    tcp_hdr_req_t m_hdr;
    int           m_id;
    int           m_ptr;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic tcp_hdr_req_t rand_hdr();
        tcp_hdr_req_t h;
        h.host_port = PORT_NUM_W'($urandom);
        h.dest_port = PORT_NUM_W'($urandom);
        h.seq_num   = SEQ_NUM_W'($urandom);
        h.ack_num   = ACK_NUM_W'($urandom);
        h.flags     = FLAGS_W'($urandom);
        h.window    = WINDOW_W'($urandom);
        return h;
    endfunction

    task automatic model_reset();
        m_val = 1'b0;
        m_hdr = '0;
        m_id  = 0;
        m_ptr = 0;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.src_hdr_req_val[i] = req_val[i];
            bus.src_host_port[i*PORT_NUM_W +: PORT_NUM_W] = req_hdr[i].host_port;
            bus.src_dest_port[i*PORT_NUM_W +: PORT_NUM_W] = req_hdr[i].dest_port;
            bus.src_seq_num[i*SEQ_NUM_W +: SEQ_NUM_W]     = req_hdr[i].seq_num;
            bus.src_ack_num[i*ACK_NUM_W +: ACK_NUM_W]     = req_hdr[i].ack_num;
            bus.src_flags[i*FLAGS_W +: FLAGS_W]           = req_hdr[i].flags;
            bus.src_window[i*WINDOW_W +: WINDOW_W]        = req_hdr[i].window;
        end
        bus.arb_hdr_req_rdy = arb_rdy;
    endtask

    task automatic check_outputs();
        check_eq("arb_val",   bus.arb_hdr_req_val, m_val);
        check_eq("arb_id",    bus.arb_req_id, m_id);
        check_eq("host_port", bus.arb_host_port, m_hdr.host_port);
        check_eq("dest_port", bus.arb_dest_port, m_hdr.dest_port);
        check_eq("seq_num",   bus.arb_seq_num, m_hdr.seq_num);
        check_eq("ack_num",   bus.arb_ack_num, m_hdr.ack_num);
        check_eq("flags",     bus.arb_flags, m_hdr.flags);
        check_eq("window",    bus.arb_window, m_hdr.window);
        check_eq("rr_ptr",    dut.rr_ptr_q, m_ptr);
    endtask

    // One clock: drive, check at negedge, advance model across the posedge.
    // refill=1 keeps the granted producer valid with a fresh header.
    task automatic step(input bit refill);
        int           winner;
        bit           load;
        logic [N-1:0] exp_rdy;
        apply();
        @(negedge clk);
        check_outputs();
        winner  = -1;
        exp_rdy = '0;
        load    = !m_val || arb_rdy;
        if (load) begin
            for (int k = 0; k < N; k++) begin
                if (winner < 0 && req_val[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
            end
            if (winner >= 0) exp_rdy[winner] = 1'b1;
        end
        check_eq("src_rdy", bus.src_hdr_req_rdy, exp_rdy);
        @(posedge clk);
        #1;
        if (load) begin
            if (winner >= 0) begin
                m_val = 1'b1;
                m_hdr = req_hdr[winner];
                m_id  = winner;
                m_ptr = (winner + 1) % N;
                if (refill) req_hdr[winner] = rand_hdr();
                else        req_val[winner] = 1'b0;
            end else begin
                m_val = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with every producer requesting
        rst_n   = 1'b0;
        arb_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            req_val[i] = 1'b1;
            req_hdr[i] = rand_hdr();
        end
        model_reset();
        apply();
        #12;
        check_outputs();
        check_eq("rst_src_rdy", bus.src_hdr_req_rdy, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Continuous round-robin with the assembler always ready
        for (int k = 0; k < 7; k++) begin
            step(1'b1);
            check_eq("rr_seq", bus.arb_req_id, k % 3);
            check_eq("rr_nobubble", bus.arb_hdr_req_val, 1'b1);
        end

        // Drain pending producers, then idle once
        for (int k = 0; k < 4; k++) step(1'b0);

        // Backpressure: req1 holds the slot while the assembler stalls
        for (int i = 0; i < N; i++) begin
            req_val[i] = 1'b1;
            req_hdr[i] = rand_hdr();
        end
        req_hdr[1].seq_num = 32'h1000_0001;
        arb_rdy = 1'b0;
        step(1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            check_eq("bp_id", bus.arb_req_id, 1);
            check_eq("bp_seq", bus.arb_seq_num, 32'h1000_0001);
        end
        arb_rdy = 1'b1;
        step(1'b0);
        check_eq("bp_next_id", bus.arb_req_id, 2);
        check_eq("bp_next_val", bus.arb_hdr_req_val, 1'b1);
        step(1'b0);
        step(1'b0);

        // Wrap and skip: pointer at 2, only req0/req1 requesting
        req_val[1] = 1'b1;
        req_hdr[1] = rand_hdr();
        step(1'b0);
        req_val[0] = 1'b1;
        req_hdr[0] = rand_hdr();
        req_val[1] = 1'b1;
        req_hdr[1] = rand_hdr();
        step(1'b0);
        check_eq("wrap_id", bus.arb_req_id, 0);
        check_eq("wrap_ptr", dut.rr_ptr_q, 1);
        step(1'b0);
        check_eq("wrap_next_id", bus.arb_req_id, 1);
        step(1'b0);

        // Field integrity from req2
        req_val[2] = 1'b1;
        req_hdr[2] = rand_hdr();
        req_hdr[2].host_port = 16'h1F90;
        req_hdr[2].dest_port = 16'hC350;
        req_hdr[2].ack_num   = 32'hDEAD_BEEF;
        req_hdr[2].flags     = 8'h12;
        req_hdr[2].window    = '1;
        step(1'b0);
        check_eq("fi_id", bus.arb_req_id, 2);
        check_eq("fi_host", bus.arb_host_port, 16'h1F90);
        check_eq("fi_dest", bus.arb_dest_port, 16'hC350);
        check_eq("fi_ack", bus.arb_ack_num, 32'hDEAD_BEEF);
        check_eq("fi_flags", bus.arb_flags, 8'h12);
        check_eq("fi_window", bus.arb_window, 16'hFFFF);
        step(1'b0);

        // Idle drain: one request, then nothing
        req_val[0] = 1'b1;
        req_hdr[0] = rand_hdr();
        step(1'b0);
        check_eq("idle_val_hi", bus.arb_hdr_req_val, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            check_eq("idle_val_lo", bus.arb_hdr_req_val, 1'b0);
            check_eq("idle_ptr", dut.rr_ptr_q, 1);
        end

        // Reset while an entry is pending downstream
        req_val[0] = 1'b1;
        req_hdr[0] = rand_hdr();
        req_val[1] = 1'b1;
        req_hdr[1] = rand_hdr();
        arb_rdy = 1'b0;
        step(1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs();
        check_eq("midrst_src_rdy", bus.src_hdr_req_rdy, 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        arb_rdy = 1'b1;
        step(1'b0);
        check_eq("midrst_id", bus.arb_req_id, 0);

        // Randomized traffic with random assembler backpressure
        for (int c = 0; c < 400; c++) begin
            arb_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!req_val[i] && $urandom_range(0, 1) == 1) begin
                    req_val[i] = 1'b1;
                    req_hdr[i] = rand_hdr();
                end
            end
            step(1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcp_hdr_req_arb.md
# tcp_hdr_req_arb

Round-robin arbiter sharing the single outbound TCP header assembler among NUM_REQ header producers (e.g. handshake engine, ACK generator, retransmit timer). Each producer presents a full header request; the arbiter grants one per cycle and registers it into a one-entry output stage that drives the assembler's request port. It sits between the TCP slow-path producers and the header assembler, and forwards a requester ID so downstream logic can attribute the packet.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- REQ_ID_W, $clog2(NUM_REQ), requester ID width
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- src_hdr_req_val  in  NUM_REQ  per-requester request valid
- src_hdr_req_rdy  out  NUM_REQ  per-requester accept (one-hot or zero)
- src_host_port  in  NUM_REQ*`PORT_NUM_W  flattened; requester i at slice i
- src_dest_port  in  NUM_REQ*`PORT_NUM_W  flattened
- src_seq_num  in  NUM_REQ*`SEQ_NUM_W  flattened
- src_ack_num  in  NUM_REQ*`ACK_NUM_W  flattened
- src_flags  in  NUM_REQ*`FLAGS_W  flattened
- src_window  in  NUM_REQ*(PAYLOAD_PTR_W+1)  flattened
- arb_hdr_req_val  out  1  registered request to assembler
- arb_hdr_req_rdy  in  1  assembler accepts
- arb_host_port, arb_dest_port, arb_seq_num, arb_ack_num, arb_flags, arb_window  out  matching widths  registered fields
- arb_req_id  out  REQ_ID_W  index of requester that owns the current output

## Operation
- Output stage is one register; states EMPTY (arb_hdr_req_val=0) and FULL (=1).
- load_en = !arb_hdr_req_val || arb_hdr_req_rdy.
- When load_en: winner = first i with src_hdr_req_val[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
- src_hdr_req_rdy[i] = load_en && (winner==i) && any valid; combinational, at most one bit set.
- On load_en with a winner: capture winner's fields and ID, arb_hdr_req_val<=1, rr_ptr <= (winner+1) mod NUM_REQ (wrap at NUM_REQ-1 -> 0).
- On load_en with no valid requester: arb_hdr_req_val<=0; rr_ptr and field registers hold.
- When FULL and !arb_hdr_req_rdy: all src rdy=0; output fields and ID stable.
- Simultaneous downstream accept and new request: old entry leaves, new entry loads same edge (no bubble).
- Fields pass unmodified; window is not clamped here (assembler clamps to `WIN_SIZE_W).
- Fairness: a continuously-valid requester is granted within NUM_REQ grants.
- Requesters must hold val and fields stable until rdy; arbiter makes no assumption beyond that.

## Timing
- Reset (asynchronous assertion, synchronous-to-clk release): arb_hdr_req_val=0, all arb_* fields=0, arb_req_id=0, rr_ptr=0; src_hdr_req_rdy=0 while rst_n low.
- Latency: request accepted at edge N appears on arb_* after edge N; 1 cycle.
- Throughput: one header per cycle when assembler holds rdy=1.
- Combinational path arb_hdr_req_rdy -> src_hdr_req_rdy is one AND level; no path from src_*_val to arb_* outputs.
- Reset mid-transfer: pending output entry is dropped; requester is not considered accepted unless rdy was high at an edge before reset.

## Structure
- Use widths `PORT_NUM_W, `SEQ_NUM_W, `ACK_NUM_W, `FLAGS_W from packet_defs.vh and PAYLOAD_PTR_W from tcp_pkg.
- Add to tcp_pkg: tcp_hdr_req_t packed struct (host_port, dest_port, seq_num, ack_num, flags, window) so the output register and the flattened inputs share one layout.
- One sub-module: rr_arbiter_ptr (parameterized round-robin first-valid finder producing one-hot grant and encoded winner from val vector and pointer); reusable by other slow-path arbiters.

## Test plan
- Reset: drive rst_n=0 with all src valid -> arb_hdr_req_val=0, src_hdr_req_rdy=0, rr_ptr=0; release -> first grant to req0 next cycle.
- Round-robin: NUM_REQ=3, all three valid continuously, arb_hdr_req_rdy=1 -> arb_req_id sequence 0,1,2,0,1,2, one per cycle, no bubbles.
- Backpressure: req1 loads seq_num=0x1000_0001, assembler rdy=0 for 5 cycles -> arb fields and arb_req_id=1 stable, src rdy all 0; rdy=1 -> entry leaves and next winner loads same edge.
- Wrap and skip: rr_ptr=2, only req0 and req1 valid -> req0 granted, rr_ptr becomes 1; next grant req1.
- Field integrity: req2 sends host_port=0x1F90, dest_port=0xC350, ack_num=0xDEAD_BEEF, flags=0x12, window=max -> identical values on arb_* with arb_req_id=2.
- Idle drain: single request accepted, then no valid -> arb_hdr_req_val high one cycle (rdy=1), then 0; rr_ptr unchanged while idle.
